// File: rtl/mc_fifo_pkg.sv
// Shared constants and helpers for the multi-channel FIFO host.
package mc_fifo_pkg;

    localparam int KEY_W  = 128;
    localparam int LOAD_W = 64;

    // Key LFSR feedback taps
    localparam int TAP_A = 127;
    localparam int TAP_B = 96;
    localparam int TAP_C = 64;
    localparam int TAP_D = 0;

    localparam logic [KEY_W-1:0] KEY_INIT_DEFAULT = 128'hF1F00123456789ABCDEFF1F0F1F0F1F0;

    // Ceiling log2 for elaboration-time sizing
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A channel index is always at least one bit wide, even for a single channel
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // XOR of the four feedback taps
    function automatic logic lfsr_fb(input logic [KEY_W-1:0] k);
        return k[TAP_A] ^ k[TAP_B] ^ k[TAP_C] ^ k[TAP_D];
    endfunction

endpackage

// File: rtl/mc_fifo_chan_ctrl.sv
// Pointer/flag controller for one FIFO channel. Pointers carry a wrap bit so
// full and empty are distinguishable when the address bits match.
module mc_fifo_chan_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req_i,
    input  logic                  rd_req_i,
    input  logic                  clr_err_i,
    output logic                  wr_acc_o,
    output logic                  rd_acc_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_WIDTH:0] AF_T = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_T = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    // Flags come straight from the pre-cycle pointers, so a same-cycle
    // read and write are both judged against the state before the edge.
    assign count          = wr_ptr_q - rd_ptr_q;
    assign empty_o        = (wr_ptr_q == rd_ptr_q);
    assign full_o         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                            (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign almost_full_o  = (count >= AF_T);
    assign almost_empty_o = (count <= AE_T);
    assign wr_acc_o       = wr_req_i && !full_o;
    assign rd_acc_o       = rd_req_i && !empty_o;
    assign wr_addr_o      = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr_o      = rd_ptr_q[ADDR_WIDTH-1:0];
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // Next pointers and sticky errors; a set event overrides clr_err
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = clr_err_i ? 1'b0 : ovf_q;
        unf_d    = clr_err_i ? 1'b0 : unf_q;
        if (wr_acc_o)            wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc_o)            rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_req_i && full_o)  ovf_d    = 1'b1;
        if (rd_req_i && empty_o) unf_d    = 1'b1;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule

// File: rtl/multi_channel_fifo_host.sv
// Multi-channel FIFO host: NUM_CH circular queues sharing one storage array,
// a registered read port with optional load mixing, and a traffic-driven key LFSR.
module multi_channel_fifo_host
    import mc_fifo_pkg::*;
#(
    parameter int               DATA_WIDTH = 16,
    parameter int               ADDR_WIDTH = 4,
    parameter int               NUM_CH     = 4,
    parameter int               AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int               AE_THRESH  = 2,
    parameter int               MIX_EN     = 1,
    parameter logic [KEY_W-1:0] KEY_INIT   = KEY_INIT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ch_width(NUM_CH)-1:0]   wr_ch,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    input  logic [ch_width(NUM_CH)-1:0]   rd_ch,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [NUM_CH-1:0]             full,
    output logic [NUM_CH-1:0]             empty,
    output logic [NUM_CH-1:0]             almost_full,
    output logic [NUM_CH-1:0]             almost_empty,
    output logic [NUM_CH-1:0]             overflow,
    output logic [NUM_CH-1:0]             underflow,
    output logic                          bad_ch,
    input  logic                          clr_err,
    output logic [KEY_W-1:0]              key_out,
    input  logic [LOAD_W-1:0]             load_in
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];
    logic [NUM_CH-1:0]     wr_req, rd_req, wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] wr_addr [NUM_CH];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_CH];
    logic                  wr_any, rd_any;
    logic                  wr_bad, rd_bad;
    logic [DATA_WIDTH-1:0] rd_word, mix;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  bad_q, bad_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic                  fb;
    logic                  unused_load;

    // Only the low DATA_WIDTH bits of load_in feed the datapath
    assign unused_load = ^load_in;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_req[g] = wr_en && (wr_ch == CH_W'(g));
        assign rd_req[g] = rd_en && (rd_ch == CH_W'(g));

        mc_fifo_chan_ctrl #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .AF_THRESH (AF_THRESH),
            .AE_THRESH (AE_THRESH)
        ) u_ctrl (
            .clk           (clk),
            .rst           (rst),
            .wr_req_i      (wr_req[g]),
            .rd_req_i      (rd_req[g]),
            .clr_err_i     (clr_err),
            .wr_acc_o      (wr_acc[g]),
            .rd_acc_o      (rd_acc[g]),
            .wr_addr_o     (wr_addr[g]),
            .rd_addr_o     (rd_addr[g]),
            .full_o        (full[g]),
            .empty_o       (empty[g]),
            .almost_full_o (almost_full[g]),
            .almost_empty_o(almost_empty[g]),
            .overflow_o    (overflow[g]),
            .underflow_o   (underflow[g])
        );
    end

    // Out-of-range indices only exist when NUM_CH is not a power of two
    if ((1 << CH_W) > NUM_CH) begin : g_range
        assign wr_bad = wr_en && (wr_ch >= CH_W'(NUM_CH));
        assign rd_bad = rd_en && (rd_ch >= CH_W'(NUM_CH));
    end else begin : g_no_range
        assign wr_bad = 1'b0;
        assign rd_bad = 1'b0;
    end

    assign wr_any = |wr_acc;
    assign rd_any = |rd_acc;
    assign mix    = (MIX_EN != 0) ? load_in[DATA_WIDTH-1:0] : '0;
    assign fb     = lfsr_fb(key_q);

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_acc[c]) mem_q[c][wr_addr[c]] <= wr_data;
        end
    end

    // Select the word being read by the one accepting channel
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_acc[c]) rd_word = mem_q[c][rd_addr[c]];
        end
    end

    // Next read register, bad-channel flag and key
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_any;
        bad_d      = clr_err ? 1'b0 : bad_q;
        key_d      = key_q;
        if (rd_any)           rd_data_d = rd_word ^ mix;
        if (wr_bad || rd_bad) bad_d     = 1'b1;
        if (wr_any)           key_d     = {key_q[KEY_W-2:0], fb ^ wr_data[DATA_WIDTH-1]};
        else if (rd_any)      key_d     = {key_q[KEY_W-2:0], fb};
    end

    // Top-level registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            bad_q      <= 1'b0;
            key_q      <= KEY_INIT;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            bad_q      <= bad_d;
            key_q      <= key_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign bad_ch   = bad_q;
    assign key_out  = key_q;

endmodule

// File: tb/tb_multi_channel_fifo_host.sv
// Bench for multi_channel_fifo_host: queue-based reference model compared
// every cycle, plus directed literal expectations.
module tb_multi_channel_fifo_host;

    localparam int DEPTH = 4;
    localparam logic [127:0] KEY_INIT = 128'hF1F00123456789ABCDEFF1F0F1F0F1F0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: NUM_CH=2, MIX_EN=1
    logic         wr_en = 0, wr_ch = 0, rd_en = 0, rd_ch = 0, clr_err = 0;
    logic [15:0]  wr_data = 0;
    logic [63:0]  load_in = 0;
    logic [15:0]  rd_data;
    logic         rd_valid, bad_ch;
    logic [1:0]   full, empty, afull, aempty, ovf, unf;
    logic [127:0] key_out;

    // second instance: NUM_CH=3, MIX_EN=0
    logic         wr_en3 = 0, rd_en3 = 0, clr_err3 = 0;
    logic [1:0]   wr_ch3 = 0, rd_ch3 = 0;
    logic [15:0]  wr_data3 = 0;
    logic [63:0]  load_in3 = 0;
    logic [15:0]  rd_data3;
    logic         rd_valid3, bad_ch3;
    logic [2:0]   full3, empty3, afull3, aempty3, ovf3, unf3;
    logic [127:0] key_out3;

    multi_channel_fifo_host #(
        .DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_CH(2),
        .AF_THRESH(3), .AE_THRESH(1), .MIX_EN(1)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty),
        .overflow(ovf), .underflow(unf), .bad_ch(bad_ch), .clr_err(clr_err),
        .key_out(key_out), .load_in(load_in)
    );

    multi_channel_fifo_host #(
        .DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_CH(3),
        .AF_THRESH(3), .AE_THRESH(1), .MIX_EN(0)
    ) u_dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
        .rd_en(rd_en3), .rd_ch(rd_ch3), .rd_data(rd_data3), .rd_valid(rd_valid3),
        .full(full3), .empty(empty3), .almost_full(afull3), .almost_empty(aempty3),
        .overflow(ovf3), .underflow(unf3), .bad_ch(bad_ch3), .clr_err(clr_err3),
        .key_out(key_out3), .load_in(load_in3)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model (main instance) ----------------
    logic [15:0]  mq0[$];
    logic [15:0]  mq1[$];
    logic [1:0]   m_ovf = 0, m_unf = 0;
    logic         m_bad = 0;
    logic [127:0] m_key = KEY_INIT;
    logic [15:0]  m_rd_data = 0;
    logic         m_rd_valid = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_ovf = '0;
            m_unf = '0;
            m_bad = 1'b0;
            m_key = KEY_INIT;
            m_rd_data = '0;
            m_rd_valid = 1'b0;
        end else begin : step
            int ws, rs;
            logic wa, ra, fb;
            logic [15:0] w;
            ws = wr_ch ? mq1.size() : mq0.size();
            rs = rd_ch ? mq1.size() : mq0.size();
            wa = wr_en && (ws < DEPTH);
            ra = rd_en && (rs > 0);
            if (clr_err) begin
                m_ovf = '0;
                m_unf = '0;
                m_bad = 1'b0;
            end
            if (wr_en && ws == DEPTH) m_ovf[wr_ch] = 1'b1;
            if (rd_en && rs == 0)     m_unf[rd_ch] = 1'b1;
            m_rd_valid = ra;
            if (ra) begin
                if (rd_ch) w = mq1.pop_front();
                else       w = mq0.pop_front();
                m_rd_data = w ^ load_in[15:0];
            end
            if (wa) begin
                if (wr_ch) mq1.push_back(wr_data);
                else       mq0.push_back(wr_data);
            end
            fb = m_key[127] ^ m_key[96] ^ m_key[64] ^ m_key[0];
            if (wa)      m_key = {m_key[126:0], fb ^ wr_data[15]};
            else if (ra) m_key = {m_key[126:0], fb};
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_rd_valid", rd_valid, m_rd_valid);
            chk("m_rd_data", rd_data, m_rd_data);
            chk("m_full", full, {mq1.size() == DEPTH, mq0.size() == DEPTH});
            chk("m_empty", empty, {mq1.size() == 0, mq0.size() == 0});
            chk("m_afull", afull, {mq1.size() >= 3, mq0.size() >= 3});
            chk("m_aempty", aempty, {mq1.size() <= 1, mq0.size() <= 1});
            chk("m_ovf", ovf, m_ovf);
            chk("m_unf", unf, m_unf);
            chk("m_bad", bad_ch, m_bad);
            chk("m_key", key_out, m_key);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic ch, input logic [15:0] d);
        wr_en = 1; wr_ch = ch; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic rd(input logic ch, input logic [63:0] ld);
        rd_en = 1; rd_ch = ch; load_in = ld;
        tick();
        rd_en = 0; load_in = '0;
    endtask

    task automatic both(input logic rch, input logic wch, input logic [15:0] d);
        rd_en = 1; rd_ch = rch; wr_en = 1; wr_ch = wch; wr_data = d;
        tick();
        rd_en = 0; wr_en = 0;
    endtask

    task automatic clr();
        clr_err = 1;
        tick();
        clr_err = 0;
    endtask

    // watchdog: the sequence below is a few hundred cycles at most
    initial begin
        #100000;
        $display("FAIL watchdog at %0t: actual=running required=finished", $time);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        tick();
        tick();
        cmp_on = 1;
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_aempty", aempty, 2'b11);
        chk("rst_afull", afull, 2'b00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_key", key_out, KEY_INIT);
        rst = 0;

        // read on empty channel: rejected, key untouched
        rd(0, 0);
        chk("unf_flag", unf, 2'b01);
        chk("unf_rd_valid", rd_valid, 1'b0);
        chk("unf_key", key_out, KEY_INIT);
        clr();
        chk("unf_clr", unf, 2'b00);

        // independence between channels; first accepted write shifts key once
        wr(0, 16'h1111);
        chk("key_first_step", key_out, 128'hE3E002468ACF13579BDFE3E1E3E1E3E1);
        wr(0, 16'h2222);
        wr(1, 16'hAAAA);
        rd(1, 0);
        chk("ind_rdv1", rd_valid, 1'b1);
        chk("ind_rd1", rd_data, 16'hAAAA);
        rd(0, 0);
        chk("ind_rd2", rd_data, 16'h1111);
        rd(0, 0);
        chk("ind_rd3", rd_data, 16'h2222);
        tick();
        chk("ind_rdv_idle", rd_valid, 1'b0);
        chk("ind_rd_hold", rd_data, 16'h2222);
        chk("ind_empty", empty, 2'b11);

        // fill ch1 to full, then overflow
        wr(1, 16'h1000);
        wr(1, 16'h1001);
        chk("af_at2", afull, 2'b00);
        wr(1, 16'h1002);
        chk("af_at3", afull, 2'b10);
        chk("full_at3", full, 2'b00);
        wr(1, 16'h1003);
        chk("full_at4", full, 2'b10);
        wr(1, 16'hDEAD);
        chk("ovf_set", ovf, 2'b10);
        chk("ovf_ch0_empty", empty[0], 1'b1);
        clr_err = 1;
        wr(1, 16'hBEEF);
        clr_err = 0;
        chk("ovf_set_beats_clr", ovf, 2'b10);
        clr();
        chk("ovf_clr", ovf, 2'b00);
        rd(1, 0);
        chk("ovf_data0", rd_data, 16'h1000);
        rd(1, 0);
        rd(1, 0);
        rd(1, 0);
        chk("ovf_data3", rd_data, 16'h1003);
        chk("drain_empty", empty, 2'b11);

        // load mixing
        wr(0, 16'h1234);
        rd(0, 64'h00000000000000FF);
        chk("mix_on", rd_data, 16'h12CB);

        // second instance: bad channel and mixing disabled
        wr_en3 = 1; wr_ch3 = 2'd3; wr_data3 = 16'h7777;
        tick();
        wr_en3 = 0;
        chk("bad_ch_set", bad_ch3, 1'b1);
        chk("bad_ch_no_ptr", empty3, 3'b111);
        clr_err3 = 1;
        tick();
        clr_err3 = 0;
        chk("bad_ch_clr", bad_ch3, 1'b0);
        wr_en3 = 1; wr_ch3 = 2'd0; wr_data3 = 16'h1234;
        tick();
        wr_en3 = 0;
        rd_en3 = 1; rd_ch3 = 2'd0; load_in3 = 64'h00000000000000FF;
        tick();
        rd_en3 = 0; load_in3 = '0;
        chk("mix_off", rd_data3, 16'h1234);
        chk("mix_off_rdv", rd_valid3, 1'b1);

        // simultaneous on a full channel: write rejected, read accepted
        wr(0, 16'h0A00);
        wr(0, 16'h0A01);
        wr(0, 16'h0A02);
        wr(0, 16'h0A03);
        chk("sim_full_pre", full, 2'b01);
        both(0, 0, 16'hBEEF);
        chk("sim_full_ovf", ovf, 2'b01);
        chk("sim_full_data", rd_data, 16'h0A00);
        chk("sim_full_cnt3_full", full, 2'b00);
        chk("sim_full_cnt3_af", afull, 2'b01);
        rd(0, 0);
        rd(0, 0);
        rd(0, 0);
        chk("sim_drain_last", rd_data, 16'h0A03);

        // simultaneous on an empty channel: read rejected, write accepted
        both(0, 0, 16'h5555);
        chk("sim_empty_unf", unf, 2'b01);
        chk("sim_empty_rdv", rd_valid, 1'b0);
        chk("sim_empty_cnt1", empty, 2'b11 & 2'b10);
        chk("sim_empty_ae", aempty, 2'b11);

        // both accepted on one channel, then on different channels
        both(0, 0, 16'h6666);
        chk("sim_mid_data", rd_data, 16'h5555);
        chk("sim_mid_empty", empty, 2'b10);
        both(0, 1, 16'h7777);
        chk("sim_diff_data", rd_data, 16'h6666);
        chk("sim_diff_empty", empty, 2'b01);
        rd(0, 0);
        chk("rejected_only_rdv", rd_valid, 1'b0);

        // asynchronous reset in the middle of a burst
        wr(0, 16'h4242);
        rd_en = 1; rd_ch = 0; wr_en = 1; wr_ch = 1; wr_data = 16'h9999;
        tick();
        chk("burst_rdv", rd_valid, 1'b1);
        #2;
        rst = 1;
        #1;
        chk("mid_rst_rdv", rd_valid, 1'b0);
        chk("mid_rst_key", key_out, KEY_INIT);
        chk("mid_rst_empty", empty, 2'b11);
        chk("mid_rst_unf", unf, 2'b00);
        chk("mid_rst_rd_data", rd_data, 16'h0000);
        rd_en = 0; wr_en = 0;
        tick();
        rst = 0;
        tick();
        wr(1, 16'h0F0F);
        rd(1, 0);
        chk("post_rst_data", rd_data, 16'h0F0F);
        tick();
        tick();

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
